// File: rtl/instruction_decode_stage_pkg.sv
// Shared opcode encodings, decoded flag bundle and stage FSM states
// for the instruction decode stage.
package decode_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_MULI = 3'd3;
    localparam logic [2:0] OP_WAIT = 3'd4;
    localparam logic [2:0] OP_LDSW = 3'd5;

    typedef struct packed {
        logic add;
        logic imm;
        logic load;
        logic wr_res;
        logic illegal;
    } dec_flags_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Handshake and decoded-bundle bus between the fetch side, the decode stage
// and the execute stage.
interface instruction_decode_stage_if #(
    parameter int INSTR_WIDTH    = 16,
    parameter int OPCODE_WIDTH   = 3,
    parameter int REG_ADDR_WIDTH = 3
);
    localparam int IMM_WIDTH = INSTR_WIDTH - OPCODE_WIDTH - 2*REG_ADDR_WIDTH;

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [INSTR_WIDTH-1:0]    in_instr;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_f_add;
    logic                      out_f_imm;
    logic                      out_f_load;
    logic                      out_f_wr_res;
    logic                      out_f_illegal;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic [REG_ADDR_WIDTH-1:0] out_rs1;
    logic [REG_ADDR_WIDTH-1:0] out_rs2;
    logic [IMM_WIDTH-1:0]      out_imm;
    logic                      stalled;

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_f_add, out_f_imm, out_f_load,
               out_f_wr_res, out_f_illegal, out_rd, out_rs1, out_rs2,
               out_imm, stalled
    );

    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_f_add, out_f_imm, out_f_load,
               out_f_wr_res, out_f_illegal, out_rd, out_rs1, out_rs2,
               out_imm, stalled
    );

endinterface

// File: rtl/instruction_decode_stage_opcode_flag_decode.sv
// Combinational opcode to control-flag mapping; unknown codes raise illegal.
module opcode_flag_decode
    import decode_pkg::*;
#(
    parameter int OPCODE_WIDTH = 3
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output dec_flags_t              flags
);

    always_comb begin
        flags = '0;
        case (opcode)
            OPCODE_WIDTH'(OP_ADD):  begin flags.add = 1'b1; flags.wr_res = 1'b1; end
            OPCODE_WIDTH'(OP_ADDI): begin flags.add = 1'b1; flags.imm = 1'b1; flags.wr_res = 1'b1; end
            OPCODE_WIDTH'(OP_MUL):  flags.wr_res = 1'b1;
            OPCODE_WIDTH'(OP_MULI): begin flags.imm = 1'b1; flags.wr_res = 1'b1; end
            OPCODE_WIDTH'(OP_LDSW): begin flags.load = 1'b1; flags.wr_res = 1'b1; end
            // WAIT is executed inside the stage and never reaches execute
            OPCODE_WIDTH'(OP_WAIT): flags = '0;
            default:                flags.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered decode stage: one-entry valid/ready output register, with WAIT
// executed locally as a programmable stall.
module instruction_decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_WIDTH    = 16,
    parameter int OPCODE_WIDTH   = 3,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    instruction_decode_stage_if.slave   bus
);

    localparam int IMM_WIDTH = INSTR_WIDTH - OPCODE_WIDTH - 2*REG_ADDR_WIDTH;

    if (IMM_WIDTH < REG_ADDR_WIDTH) begin : g_bad_imm_width
        $error("instruction_decode_stage: immediate field narrower than a register address");
    end

    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [REG_ADDR_WIDTH-1:0] rd_field;
    logic [REG_ADDR_WIDTH-1:0] rs1_field;
    logic [IMM_WIDTH-1:0]      imm_field;
    dec_flags_t                flags_dec;
    dec_flags_t                flags_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q;
    logic [IMM_WIDTH-1:0]      imm_q;
    logic                      out_valid_q;
    state_t                    state, state_next;
    logic [IMM_WIDTH-1:0]      count, count_next;
    logic                      accept;
    logic                      is_wait;

    assign opcode    = bus.in_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign rd_field  = bus.in_instr[INSTR_WIDTH-OPCODE_WIDTH-1 -: REG_ADDR_WIDTH];
    assign rs1_field = bus.in_instr[INSTR_WIDTH-OPCODE_WIDTH-REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
    assign imm_field = bus.in_instr[IMM_WIDTH-1:0];

    opcode_flag_decode #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_flag_decode (
        .opcode (opcode),
        .flags  (flags_dec)
    );

    assign is_wait      = (opcode == OPCODE_WIDTH'(OP_WAIT));
    assign bus.in_ready = (state == RUN) && !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_next = state;
        count_next = count;
        if (bus.flush) begin
            state_next = RUN;
            count_next = '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept && is_wait && (imm_field != '0)) begin
                        state_next = STALL;
                        count_next = imm_field;
                    end
                end
                STALL: begin
                    count_next = count - IMM_WIDTH'(1);
                    if (count == IMM_WIDTH'(1)) state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            count       <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            // An accepted WAIT falls through to the drain branch, so a pending
            // bundle can still leave while the stall starts.
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (accept && !is_wait) begin
                out_valid_q <= 1'b1;
                flags_q     <= flags_dec;
                rd_q        <= rd_field;
                rs1_q       <= rs1_field;
                rs2_q       <= imm_field[REG_ADDR_WIDTH-1:0];
                imm_q       <= imm_field;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_f_add     = flags_q.add;
    assign bus.out_f_imm     = flags_q.imm;
    assign bus.out_f_load    = flags_q.load;
    assign bus.out_f_wr_res  = flags_q.wr_res;
    assign bus.out_f_illegal = flags_q.illegal;
    assign bus.out_rd        = rd_q;
    assign bus.out_rs1       = rs1_q;
    assign bus.out_rs2       = rs2_q;
    assign bus.out_imm       = imm_q;
    assign bus.stalled       = (state == STALL);

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: directed scenarios with literal
// expectations plus randomized traffic against a cycle-indexed reference model.
module tb_instruction_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instruction_decode_stage_if #(.INSTR_WIDTH(16), .OPCODE_WIDTH(3), .REG_ADDR_WIDTH(3)) ifc ();

    instruction_decode_stage #(.INSTR_WIDTH(16), .OPCODE_WIDTH(3), .REG_ADDR_WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: flags indexed by opcode {add,imm,load,wr_res,illegal}
    logic [4:0] ftab [8] = '{5'b10010, 5'b11010, 5'b00010, 5'b01010,
                             5'b00000, 5'b00110, 5'b00001, 5'b00001};
    bit         known     = 0;
    longint     cyc_no    = 0;
    longint     stall_end = -1;
    bit         m_valid   = 0;
    logic [4:0] m_flags   = '0;
    logic [2:0] m_rd = '0, m_rs1 = '0, m_rs2 = '0;
    logic [6:0] m_imm = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int imm);
        logic [15:0] w;
        w = {op[2:0], rd[2:0], rs1[2:0], imm[6:0]};
        return w;
    endfunction

    function automatic bit exp_stalled();
        return known && (cyc_no <= stall_end);
    endfunction

    function automatic bit exp_ready();
        return !exp_stalled() && !ifc.flush && (!m_valid || ifc.out_ready);
    endfunction

    function automatic logic [4:0] dut_flags();
        return {ifc.out_f_add, ifc.out_f_imm, ifc.out_f_load, ifc.out_f_wr_res, ifc.out_f_illegal};
    endfunction

    // Compare DUT against the model in the middle of every cycle
    always @(negedge clk) begin
        if (known) begin
            chk("in_ready",  ifc.in_ready,  exp_ready());
            chk("out_valid", ifc.out_valid, m_valid);
            chk("stalled",   ifc.stalled,   exp_stalled());
            if (m_valid) begin
                chk("flags",   dut_flags(),  m_flags);
                chk("out_rd",  ifc.out_rd,   m_rd);
                chk("out_rs1", ifc.out_rs1,  m_rs1);
                chk("out_rs2", ifc.out_rs2,  m_rs2);
                chk("out_imm", ifc.out_imm,  m_imm);
            end
        end
    end

    task automatic model_step();
        bit rdy;
        logic [15:0] w;
        rdy = exp_ready();
        w   = ifc.in_instr;
        if (!rst_n) begin
            known = 1; m_valid = 0; m_flags = '0;
            m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
            stall_end = cyc_no;
        end else if (ifc.flush) begin
            m_valid = 0;
            stall_end = cyc_no;
        end else if (ifc.in_valid && rdy) begin
            if (w[15:13] == 3'd4) begin
                if (w[6:0] != 0) stall_end = cyc_no + longint'(w[6:0]);
                if (ifc.out_ready) m_valid = 0;
            end else begin
                m_valid = 1;
                m_flags = ftab[w[15:13]];
                m_rd = w[12:10]; m_rs1 = w[9:7]; m_imm = w[6:0]; m_rs2 = w[2:0];
            end
        end else if (ifc.out_ready) begin
            m_valid = 0;
        end
        cyc_no++;
    endtask

    task automatic drive(input bit v, input logic [15:0] ins, input bit ordy, input bit fl, input bit rn);
        ifc.in_valid  = v;
        ifc.in_instr  = ins;
        ifc.out_ready = ordy;
        ifc.flush     = fl;
        rst_n         = rn;
    endtask

    task automatic fin();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_random(input int n);
        int op, imm;
        for (int i = 0; i < n; i++) begin
            op  = int'($urandom_range(0, 7));
            imm = int'($urandom_range(0, 127));
            if (op == 4) imm = ($urandom_range(0, 15) == 0) ? 40 : int'($urandom_range(0, 6));
            drive($urandom_range(0, 3) != 0,
                  enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 40) == 0,
                  $urandom_range(0, 300) != 0);
            #1;
            fin();
        end
    endtask

    initial begin
        // Reset / idle
        drive(0, '0, 1, 0, 0); #1; fin();
        drive(0, '0, 1, 0, 0); #1; fin();
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_stalled",   ifc.stalled,   0);
        chk("rst_flags",     dut_flags(),   0);
        chk("rst_fields",    {ifc.out_rd, ifc.out_rs1, ifc.out_rs2, ifc.out_imm}, 0);
        drive(0, '0, 1, 0, 1); #1;
        chk("rst_in_ready", ifc.in_ready, 1);
        fin();

        // Back-to-back stream
        drive(1, enc(0, 1, 2, 3), 1, 0, 1); #1; fin();
        chk("add_valid", ifc.out_valid, 1);
        chk("add_flags", dut_flags(), 5'b10010);
        chk("add_rd",    ifc.out_rd, 1);
        drive(1, enc(1, 4, 1, 5), 1, 0, 1); #1; fin();
        chk("addi_flags", dut_flags(), 5'b11010);
        chk("addi_imm",   ifc.out_imm, 5);
        drive(1, enc(5, 7, 0, 0), 1, 0, 1); #1; fin();
        chk("ldsw_flags", dut_flags(), 5'b00110);
        chk("ldsw_rd",    ifc.out_rd, 7);
        drive(0, '0, 1, 0, 1); #1; fin();
        chk("drain_valid", ifc.out_valid, 0);

        // Backpressure with MUL pending
        drive(1, enc(2, 3, 4, 6), 1, 0, 1); #1; fin();
        for (int i = 0; i < 4; i++) begin
            drive(1, enc(0, 5, 5, 1), 0, 0, 1); #1;
            chk("bp_in_ready", ifc.in_ready, 0);
            fin();
            chk("bp_hold", {ifc.out_valid, dut_flags(), ifc.out_rd}, {1'b1, 5'b00010, 3'd3});
        end
        drive(1, enc(0, 5, 5, 1), 1, 0, 1); #1;
        chk("bp_release_ready", ifc.in_ready, 1);
        fin();
        chk("bp_next_rd", ifc.out_rd, 5);

        // WAIT #3 then ADD
        drive(1, enc(4, 0, 0, 3), 1, 0, 1); #1; fin();
        chk("wait_no_bundle", ifc.out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, enc(0, 2, 2, 2), 1, 0, 1); #1;
            chk("wait3_ready", ifc.in_ready, 0);
            chk("wait3_stalled", ifc.stalled, 1);
            fin();
        end
        drive(1, enc(0, 2, 2, 2), 1, 0, 1); #1;
        chk("wait3_done_ready", ifc.in_ready, 1);
        fin();

        // WAIT #0 then ADD
        drive(1, enc(4, 0, 0, 0), 1, 0, 1); #1; fin();
        drive(1, enc(0, 6, 1, 9), 1, 0, 1); #1;
        chk("wait0_ready", ifc.in_ready, 1);
        fin();
        chk("wait0_add_rd", ifc.out_rd, 6);

        // Illegal opcodes
        drive(1, enc(6, 5, 6, 7'h55), 1, 0, 1); #1; fin();
        chk("ill6_flags",  dut_flags(), 5'b00001);
        chk("ill6_fields", {ifc.out_rd, ifc.out_rs1, ifc.out_imm, ifc.out_rs2}, {3'd5, 3'd6, 7'h55, 3'd5});
        drive(1, enc(7, 2, 3, 7'h2A), 1, 0, 1); #1; fin();
        chk("ill7_flags",  dut_flags(), 5'b00001);
        chk("ill7_fields", {ifc.out_rd, ifc.out_rs1, ifc.out_imm}, {3'd2, 3'd3, 7'h2A});

        // Flush during WAIT #20
        drive(1, enc(4, 0, 0, 20), 1, 0, 1); #1; fin();
        for (int i = 0; i < 10; i++) begin drive(0, '0, 1, 0, 1); #1; fin(); end
        drive(0, '0, 1, 1, 1); #1;
        chk("flush_cycle_ready", ifc.in_ready, 0);
        fin();
        chk("flush_stalled", ifc.stalled, 0);
        chk("flush_valid",   ifc.out_valid, 0);
        drive(0, '0, 1, 0, 1); #1;
        chk("flush_after_ready", ifc.in_ready, 1);
        fin();

        // Reset during WAIT #20
        drive(1, enc(4, 0, 0, 20), 1, 0, 1); #1; fin();
        for (int i = 0; i < 5; i++) begin drive(0, '0, 1, 0, 1); #1; fin(); end
        drive(0, '0, 0, 0, 0); #1; fin();
        chk("rstmid_stalled", ifc.stalled, 0);
        drive(0, '0, 1, 0, 1); #1;
        chk("rstmid_ready", ifc.in_ready, 1);
        fin();

        // Maximum stall: WAIT with all-ones immediate
        drive(1, enc(4, 0, 0, 127), 1, 0, 1); #1; fin();
        for (int i = 0; i < 127; i++) begin
            drive(1, enc(1, 1, 1, 1), 1, 0, 1); #1;
            if (i == 126) chk("max_last_stalled", ifc.stalled, 1);
            fin();
        end
        drive(1, enc(1, 1, 1, 1), 1, 0, 1); #1;
        chk("max_release_ready", ifc.in_ready, 1);
        fin();

        run_random(2500);
        drive(0, '0, 1, 0, 1); #1; fin();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
